// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN frame layout, fetch state encoding and frame struct
package can_pkg;

    // Tx/Rx FIFO word width and field positions within a word.
    // Bits [FRAME_W-1:FRAME_USED_W] are reserved and ignored.
    localparam int FRAME_W      = 128;
    localparam int DATA_LSB     = 0;
    localparam int DATA_W       = 64;
    localparam int DLC_LSB      = 64;
    localparam int DLC_W        = 4;
    localparam int RTR_BIT      = 68;
    localparam int IDE_BIT      = 69;
    localparam int ID_LSB       = 70;
    localparam int ID_W         = 29;
    localparam int STD_ID_W     = 11;
    localparam int FRAME_USED_W = ID_LSB + ID_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_CAPTURE,
        ST_PRESENT,
        ST_BUSY
    } tx_fetch_state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              ide;
        logic              rtr;
        logic [DLC_W-1:0]  dlc;
        logic [3:0]        data_len;
        logic [DATA_W-1:0] data;
    } can_frame_t;

    // Payload byte count: remote frames carry none, DLC codes 9..15 mean 8.
    function automatic logic [3:0] data_len_f(input logic rtr, input logic [DLC_W-1:0] dlc);
        if (rtr) begin
            return 4'd0;
        end
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction

endpackage

// File: rtl/can_tx_frame_fetch_if.sv
// rtl/can_tx_frame_fetch_if.sv - fetch stage to serializer frame handshake
// master: fetch stage (drives frame fields + valid, receives ready/done/error)
// slave : serializer
interface can_tx_frame_fetch_if;
    import can_pkg::*;

    logic              o_frame_valid;
    logic              i_frame_ready;
    logic [ID_W-1:0]   o_id;
    logic              o_ide;
    logic              o_rtr;
    logic [DLC_W-1:0]  o_dlc;
    logic [3:0]        o_data_len;
    logic [DATA_W-1:0] o_data;
    logic              i_tx_done;
    logic              i_tx_error;

    modport master (
        output o_frame_valid, o_id, o_ide, o_rtr, o_dlc, o_data_len, o_data,
        input  i_frame_ready, i_tx_done, i_tx_error
    );

    modport slave (
        input  o_frame_valid, o_id, o_ide, o_rtr, o_dlc, o_data_len, o_data,
        output i_frame_ready, i_tx_done, i_tx_error
    );

endinterface

// File: rtl/can_frame_unpack.sv
// rtl/can_frame_unpack.sv - combinational FIFO word to sanitised CAN frame fields
// i_word  : used bits [98:0] of a Tx FIFO word
// o_frame : id (standard ids masked to 11 bits), ide, rtr, raw dlc,
//           data_len 0..8, data with bytes beyond data_len zeroed
module can_frame_unpack
    import can_pkg::*;
(
    input  logic [FRAME_USED_W-1:0] i_word,
    output can_frame_t              o_frame
);

    logic [ID_W-1:0]   raw_id;
    logic [DATA_W-1:0] raw_data;
    logic [3:0]        len;

    assign raw_id   = i_word[ID_LSB +: ID_W];
    assign raw_data = i_word[DATA_LSB +: DATA_W];
    assign len      = data_len_f(i_word[RTR_BIT], i_word[DLC_LSB +: DLC_W]);

    always_comb begin
        o_frame          = '0;
        o_frame.ide      = i_word[IDE_BIT];
        o_frame.rtr      = i_word[RTR_BIT];
        o_frame.dlc      = i_word[DLC_LSB +: DLC_W];
        o_frame.data_len = len;
        o_frame.id       = i_word[IDE_BIT] ? raw_id
                                           : {{(ID_W-STD_ID_W){1'b0}}, raw_id[STD_ID_W-1:0]};
        for (int b = 0; b < 8; b++) begin
            if (b < int'(len)) begin
                o_frame.data[b*8 +: 8] = raw_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/can_tx_frame_fetch.sv
// rtl/can_tx_frame_fetch.sv - Tx FIFO pop, frame unpack and retrying hand-off to the serializer
// i_sys_clk, i_reset     : clock, synchronous active-high reset
// o_fifo_r_en            : one-cycle registered read strobe to the Tx FIFO
// i_fifo_r_data          : Tx FIFO registered read data
// i_fifo_empty           : Tx FIFO empty flag, sampled only in IDLE
// ser                    : frame fields + valid/ready + tx_done/tx_error
// o_tx_ack               : pulse, frame transmitted
// o_retry_exhausted      : pulse, frame dropped after MAX_RETRY failed attempts
// o_busy                 : high whenever the FSM is not in IDLE
module can_tx_frame_fetch #(
    parameter int FRAME_W   = can_pkg::FRAME_W,
    parameter int MAX_RETRY = 8
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    output logic                  o_fifo_r_en,
    input  logic [FRAME_W-1:0]    i_fifo_r_data,
    input  logic                  i_fifo_empty,
    can_tx_frame_fetch_if.master  ser,
    output logic                  o_tx_ack,
    output logic                  o_retry_exhausted,
    output logic                  o_busy
);
    import can_pkg::*;

    localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

    tx_fetch_state_t state;
    can_frame_t      unpacked;
    can_frame_t      frame_q;
    logic [3:0]      retry_cnt;
    logic [3:0]      retry_nxt;
    logic            frame_valid_q;
    logic            unused_rsvd;

    assign unused_rsvd = ^i_fifo_r_data[FRAME_W-1:FRAME_USED_W];

    can_frame_unpack u_unpack (
        .i_word  (i_fifo_r_data[FRAME_USED_W-1:0]),
        .o_frame (unpacked)
    );

    assign retry_nxt = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state             <= ST_IDLE;
            frame_q           <= '0;
            retry_cnt         <= '0;
            frame_valid_q     <= 1'b0;
            o_fifo_r_en       <= 1'b0;
            o_tx_ack          <= 1'b0;
            o_retry_exhausted <= 1'b0;
            o_busy            <= 1'b0;
        end else begin
            o_fifo_r_en       <= 1'b0;
            o_tx_ack          <= 1'b0;
            o_retry_exhausted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!i_fifo_empty) begin
                        state       <= ST_POP;
                        o_fifo_r_en <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                ST_POP: state <= ST_WAIT;
                // FIFO read data becomes valid one cycle after the strobe.
                ST_WAIT: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    frame_q       <= unpacked;
                    retry_cnt     <= '0;
                    frame_valid_q <= 1'b1;
                    state         <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (ser.i_frame_ready) begin
                        frame_valid_q <= 1'b0;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // done takes priority over a coincident error
                    if (ser.i_tx_done) begin
                        o_tx_ack <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (ser.i_tx_error) begin
                        retry_cnt <= retry_nxt;
                        if (retry_nxt == MAX_RETRY_L) begin
                            o_retry_exhausted <= 1'b1;
                            o_busy            <= 1'b0;
                            state             <= ST_IDLE;
                        end else begin
                            frame_valid_q <= 1'b1;
                            state         <= ST_PRESENT;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    frame_valid_q <= 1'b0;
                    o_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign ser.o_frame_valid = frame_valid_q;
    assign ser.o_id          = frame_q.id;
    assign ser.o_ide         = frame_q.ide;
    assign ser.o_rtr         = frame_q.rtr;
    assign ser.o_dlc         = frame_q.dlc;
    assign ser.o_data_len    = frame_q.data_len;
    assign ser.o_data        = frame_q.data;

endmodule

// File: doc/can_tx_frame_fetch.md
# can_tx_frame_fetch

Transmit-side fetch stage between the Tx FIFO and the CAN bit-stream serializer. Pops one 128-bit frame word from the Tx FIFO, unpacks and sanitises the fields, presents them to the serializer over a valid/ready handshake, and holds the frame until the serializer reports success or error. Errors trigger retransmission up to a bounded retry count.

## Interface
- `FRAME_W`, 128: FIFO word width; must match Tx FIFO `DATA_WIDTH`.
- `MAX_RETRY`, 8: transmit attempts per frame before the frame is dropped; range 1..15.

- `i_sys_clk` in 1: system clock; single clock domain.
- `i_reset` in 1: synchronous, active-high reset.
- `o_fifo_r_en` in→out 1: read strobe to Tx FIFO; registered.
- `i_fifo_r_data` in `FRAME_W`: Tx FIFO read data.
- `i_fifo_empty` in 1: Tx FIFO empty flag.
- `o_frame_valid` out 1: frame fields valid for the serializer.
- `i_frame_ready` in 1: serializer accepts the frame.
- `o_id` out 29: identifier; bits [28:11] forced to 0 when `o_ide`=0.
- `o_ide` out 1: extended-ID flag.
- `o_rtr` out 1: remote-frame flag.
- `o_dlc` out 4: raw DLC, passed through unchanged.
- `o_data_len` out 4: payload bytes, 0..8.
- `o_data` out 64: payload; byte 0 is in [7:0].
- `i_tx_done` in 1: one-cycle pulse; frame sent and acknowledged.
- `i_tx_error` in 1: one-cycle pulse; arbitration lost or bus error.
- `o_tx_ack` out 1: one-cycle pulse; frame completed.
- `o_retry_exhausted` out 1: one-cycle pulse; frame dropped.
- `o_busy` out 1: high in every state except IDLE.

## Operation
FIFO word layout:
- [63:0] data
- [67:64] dlc
- [68] rtr
- [69] ide
- [98:70] id
- [127:99] reserved; ignored.

State machine:
- **IDLE.** Go to POP when `i_fifo_empty`=0.
- **POP.** Drive `o_fifo_r_en`=1 for exactly this one cycle; next state is WAIT.
- **WAIT.** Go to CAPTURE. This lets the FIFO's registered read data settle.
- **CAPTURE.** Register the unpacked fields and set retry count to 0; next state is PRESENT.
- **PRESENT.** `o_frame_valid`=1. When `i_frame_ready`=1, go to BUSY.
- **BUSY.** `o_frame_valid`=0; wait for a completion pulse.
  - `i_tx_done`: pulse `o_tx_ack` and go to IDLE.
  - `i_tx_error`: increment retry count. If the new count equals `MAX_RETRY`, pulse `o_retry_exhausted` and go to IDLE; otherwise go to PRESENT.
  - `i_tx_done` and `i_tx_error` in the same cycle: done wins.

Field rules:
- `o_data_len`: 0 if rtr=1; otherwise min(dlc, 8).
- `o_data` bytes at index ≥ `o_data_len` are driven 0.
- Retry count is 4 bits, saturating. It compares against `MAX_RETRY` after the increment.
- Field outputs hold their value from CAPTURE until the next CAPTURE.
- `i_tx_done`/`i_tx_error` outside BUSY are ignored.
- `i_fifo_empty` is sampled only in IDLE, so at most one pop is outstanding. The block never reads an empty FIFO and causes no FIFO underflow.

## Timing
- Reset value of every output is 0; the state machine resets to IDLE.
- Reset asserted in any state returns the block to IDLE on the next edge. A frame in flight is lost; no ack, no exhausted pulse.
- IDLE with FIFO non-empty to `o_frame_valid`=1 takes 4 cycles: IDLE→POP→WAIT→CAPTURE→PRESENT.
- The valid/ready transfer occurs on the edge where both signals are 1. `o_frame_valid` is low the following cycle.
- Completion pulse in BUSY leads to `o_tx_ack` or `o_retry_exhausted` high in the next cycle, for 1 cycle.
- Error in BUSY leads to `o_frame_valid`=1 again in the next cycle.
- Back-to-back frames: the earliest next `o_fifo_r_en` is 1 cycle after `o_tx_ack`, i.e. when IDLE sees the FIFO non-empty.

## Structure
- Shared package `can_pkg` holds the following, also to be used by the Rx assembler:
  - `FRAME_W` and the field bit offsets/widths (ID_LSB, DLC_LSB, etc.).
  - The `tx_fetch_state_t` enum.
  - A `can_frame_t` packed struct.
- One natural sub-module: `can_frame_unpack`. It is combinational: FIFO word in, sanitised id/ide/rtr/dlc/data_len/data out.
- The FSM and retry counter live in the top.

## Test plan
- **Single frame.** FIFO presents id=0x123, ide=0, dlc=3, data=0x..00CCBBAA; ready held high; `i_tx_done` 2 cycles later.
  - `o_fifo_r_en` pulses once.
  - `o_id`=0x123, `o_data_len`=3, `o_data`=0x0000000000CCBBAA.
  - `o_tx_ack` pulses once; back to IDLE.
- **Sanitise.** Word with ide=0, id=0x1FFFFFFF, rtr=0, dlc=12 → `o_id`=0x7FF, `o_dlc`=12, `o_data_len`=8. A second word with rtr=1, dlc=5 → `o_data_len`=0, `o_data`=0.
- **Retry then success.** Error pulses on attempts 1 and 2, done on attempt 3 → `o_frame_valid` rises 3 times with identical fields, then `o_tx_ack`; no exhausted pulse.
- **Retry exhaustion.** `MAX_RETRY`=3 with an error on every attempt → exactly 3 presentations, then one `o_retry_exhausted` pulse. The next FIFO frame is popped afterwards.
- **Simultaneous and stray events.** `i_tx_done` and `i_tx_error` together in BUSY produce `o_tx_ack` only. Pulses in IDLE/PRESENT are ignored.
- **Reset mid-operation.** Reset asserted in BUSY → every output is 0 on the next cycle. No ack; resumes fetching from a non-empty FIFO after release.
